// File: rtl/time_entry_pkg.sv
// -----------------------------------------------------------------------------
// time_entry_pkg
// Shared types and constants for the keypad time-entry register.
//   state_t      : key debouncer FSM states (IDLE, DEBOUNCE, HELD)
//   DIGIT_W      : width of one BCD digit
//   MAX_DIGITS   : number of digits held (MM:SS)
//   COUNT_W      : width of the entered-digit counter
//   is_bcd()     : true when a keypad code is a legal decimal digit
// -----------------------------------------------------------------------------
package time_entry_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_t;

   localparam int DIGIT_W    = 4;
   localparam int MAX_DIGITS = 4;
   localparam int COUNT_W    = 3;

   localparam logic [DIGIT_W-1:0] MAX_DIGIT_VAL = 4'd9;

   function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
      return (d <= MAX_DIGIT_VAL);
   endfunction

endpackage

// File: rtl/time_entry_register_key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Turns the raw active-low "key pressed" indication into a single capture
// strobe per press, after the key has been stably low for DEBOUNCE_CYCLES
// further cycles following the first low sample.
// Parameters:
//   DEBOUNCE_CYCLES : stable-press cycles before capture (1..255)
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   number  in  1 = no key pressed, 0 = key pressed
//   capture out combinational strobe, high in the cycle the digit is taken
// -----------------------------------------------------------------------------
module key_debouncer
   import time_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic number,
   output logic capture
);

   localparam logic [7:0] CNT_TARGET = 8'(DEBOUNCE_CYCLES);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!number) begin
               state_d = DEBOUNCE;
               cnt_d   = 8'd1;
            end
         end
         DEBOUNCE: begin
            if (number) begin
               // bounce or short press: abandon without capturing
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TARGET) begin
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HELD: begin
            // wait for release so a long hold yields one capture only
            cnt_d = '0;
            if (number) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      capture = (state_q == DEBOUNCE) && !number && (cnt_q == CNT_TARGET);
   end

endmodule

// File: rtl/time_entry_register.sv
// -----------------------------------------------------------------------------
// time_entry_register
// Collects up to four keypad digits into an MM:SS shift register. Each new
// digit enters at sec_ones and pushes older digits toward min_tens.
// Optional feature macro: TIME_ENTRY_SEC_CHECK_EN
//   defined   : time_valid = (sec_tens <= 5)
//   undefined : time_valid tied high
// Parameters:
//   DEBOUNCE_CYCLES : stable-press cycles before capture (1..255)
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   digits accepted only while high
//   clear        in   synchronous clear of the entered time
//   D[3:0]       in   keypad digit code
//   number       in   1 = no key, 0 = key pressed
//   min_tens, min_ones, sec_tens, sec_ones [3:0] out  entered BCD digits
//   digit_count[2:0] out  digits entered, 0..4
//   digit_pulse  out  one-cycle strobe per accepted digit
//   time_nonzero out  any digit non-zero
//   time_valid   out  entered time is legal
// -----------------------------------------------------------------------------
module time_entry_register
   import time_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               clear,
   input  logic [DIGIT_W-1:0] D,
   input  logic               number,
   output logic [DIGIT_W-1:0] min_tens,
   output logic [DIGIT_W-1:0] min_ones,
   output logic [DIGIT_W-1:0] sec_tens,
   output logic [DIGIT_W-1:0] sec_ones,
   output logic [COUNT_W-1:0] digit_count,
   output logic               digit_pulse,
   output logic               time_nonzero,
   output logic               time_valid
);

   localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(MAX_DIGITS);

   logic capture;
   logic accept_p0;

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debouncer (
      .clk     (clk),
      .rst_n   (rst_n),
      .number  (number),
      .capture (capture)
   );

   // clear has priority over a capture landing in the same cycle
   assign accept_p0 = capture && en && !clear && (digit_count < FULL_COUNT) && is_bcd(D);

   // ---- stage p0 -> p1: shift register, counter and accept strobe ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_tens    <= '0;
         min_ones    <= '0;
         sec_tens    <= '0;
         sec_ones    <= '0;
         digit_count <= '0;
         digit_pulse <= 1'b0;
      end else begin
         digit_pulse <= accept_p0;
         if (clear) begin
            min_tens    <= '0;
            min_ones    <= '0;
            sec_tens    <= '0;
            sec_ones    <= '0;
            digit_count <= '0;
         end else if (accept_p0) begin
            min_tens    <= min_ones;
            min_ones    <= sec_tens;
            sec_tens    <= sec_ones;
            sec_ones    <= D;
            digit_count <= digit_count + 1'b1;
         end
      end
   end

   assign time_nonzero = |{min_tens, min_ones, sec_tens, sec_ones};

`ifdef TIME_ENTRY_SEC_CHECK_EN
   assign time_valid = (sec_tens <= 4'd5);
`else
   assign time_valid = 1'b1;
`endif

endmodule

// File: tb/tb_time_entry_register.sv
module tb_time_entry_register;

   localparam int DC = 4;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b1;
   logic       en     = 1'b0;
   logic       clear  = 1'b0;
   logic       number = 1'b1;
   logic [3:0] D      = 4'd0;

   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic [2:0] digit_count;
   logic       digit_pulse, time_nonzero, time_valid;

   always #5 clk = ~clk;

   time_entry_register #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .clear        (clear),
      .D            (D),
      .number       (number),
      .min_tens     (min_tens),
      .min_ones     (min_ones),
      .sec_tens     (sec_tens),
      .sec_ones     (sec_ones),
      .digit_count  (digit_count),
      .digit_pulse  (digit_pulse),
      .time_nonzero (time_nonzero),
      .time_valid   (time_valid)
   );

   int total  = 0;
   int bad    = 0;
   int pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // run  : length of the current unbroken run of low 'number' samples
   // A press is taken on the (DC+1)-th consecutive low sample, once per run.
   int m_dig [4] = '{0, 0, 0, 0};   // [0]=min_tens .. [3]=sec_ones
   int m_cnt   = 0;
   int m_pulse = 0;
   int run     = 0;

   always @(posedge clk or negedge rst_n) begin : model
      int r;
      bit cap;
      if (!rst_n) begin
         run     <= 0;
         m_cnt   <= 0;
         m_pulse <= 0;
         for (int i = 0; i < 4; i++) m_dig[i] <= 0;
      end else begin
         r   = number ? 0 : ((run >= DC + 2) ? DC + 2 : run + 1);
         cap = (r == DC + 1);
         run     <= r;
         m_pulse <= 0;
         if (clear) begin
            m_cnt <= 0;
            for (int i = 0; i < 4; i++) m_dig[i] <= 0;
         end else if (cap && en && m_cnt < 4 && D <= 9) begin
            m_dig[0] <= m_dig[1];
            m_dig[1] <= m_dig[2];
            m_dig[2] <= m_dig[3];
            m_dig[3] <= int'(D);
            m_cnt    <= m_cnt + 1;
            m_pulse  <= 1;
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      int exp_nz, exp_valid;
      exp_nz = (m_dig[0] != 0 || m_dig[1] != 0 || m_dig[2] != 0 || m_dig[3] != 0) ? 1 : 0;
`ifdef TIME_ENTRY_SEC_CHECK_EN
      exp_valid = (m_dig[2] <= 5) ? 1 : 0;
`else
      exp_valid = 1;
`endif
      check("min_tens",     32'(min_tens),     32'(m_dig[0]));
      check("min_ones",     32'(min_ones),     32'(m_dig[1]));
      check("sec_tens",     32'(sec_tens),     32'(m_dig[2]));
      check("sec_ones",     32'(sec_ones),     32'(m_dig[3]));
      check("digit_count",  32'(digit_count),  32'(m_cnt));
      check("digit_pulse",  32'(digit_pulse),  32'(m_pulse));
      check("time_nonzero", 32'(time_nonzero), 32'(exp_nz));
      check("time_valid",   32'(time_valid),   32'(exp_valid));
      if (digit_pulse === 1'b1) pulses++;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic press(input logic [3:0] d, input int hold, input int gap);
      D      = d;
      number = 1'b0;
      repeat (hold) step();
      number = 1'b1;
      D      = 4'($urandom_range(0, 15));
      repeat (gap) step();
   endtask

   initial begin : stim
      int p0;
      logic [3:0] rd;
      #1 rst_n = 1'b0;
      #1;
      check("rst_count", 32'(digit_count), 0);
      check("rst_pulse", 32'(digit_pulse), 0);
      check("rst_sec_ones", 32'(sec_ones), 0);
      repeat (3) step();
      rst_n = 1'b1;
      en    = 1'b1;
      repeat (2) step();

      // four digits
      p0 = pulses;
      press(4'd1, 10, 4);
      press(4'd2, 10, 4);
      press(4'd3, 10, 4);
      press(4'd0, 10, 4);
      check("four_min_tens", 32'(min_tens), 1);
      check("four_min_ones", 32'(min_ones), 2);
      check("four_sec_tens", 32'(sec_tens), 3);
      check("four_sec_ones", 32'(sec_ones), 0);
      check("four_count", 32'(digit_count), 4);
      check("four_pulses", 32'(pulses - p0), 4);

      // fifth press while full
      p0 = pulses;
      press(4'd7, 10, 4);
      check("full_sec_ones", 32'(sec_ones), 0);
      check("full_count", 32'(digit_count), 4);
      check("full_pulses", 32'(pulses - p0), 0);

      clear = 1'b1; step(); clear = 1'b0; step();
      check("clear_count", 32'(digit_count), 0);

      // debounce boundaries
      press(4'd1, DC - 1, 4);
      check("short_press", 32'(digit_count), 0);
      press(4'd2, DC, 4);
      check("edge_press", 32'(digit_count), 0);
      press(4'd3, DC + 1, 4);
      check("min_press_count", 32'(digit_count), 1);
      check("min_press_digit", 32'(sec_ones), 3);

      // clear in the capture cycle, then a long hold
      press(4'd4, 10, 4);
      D = 4'd5; number = 1'b0;
      repeat (DC) step();
      clear = 1'b1;
      p0 = pulses;
      step();
      clear = 1'b0;
      repeat (50) step();
      check("clrcap_count", 32'(digit_count), 0);
      check("clrcap_sec_ones", 32'(sec_ones), 0);
      check("clrcap_pulses", 32'(pulses - p0), 0);
      number = 1'b1;
      repeat (4) step();

      // 09:75
      press(4'd0, 10, 4);
      press(4'd9, 10, 4);
      press(4'd7, 10, 4);
      press(4'd5, 10, 4);
      check("t0975_min_ones", 32'(min_ones), 9);
      check("t0975_sec_tens", 32'(sec_tens), 7);
      check("t0975_nonzero", 32'(time_nonzero), 1);
`ifdef TIME_ENTRY_SEC_CHECK_EN
      check("t0975_valid", 32'(time_valid), 0);
`else
      check("t0975_valid", 32'(time_valid), 1);
`endif

      // disabled entry and illegal code
      clear = 1'b1; step(); clear = 1'b0;
      en = 1'b0;
      press(4'd3, 10, 4);
      check("en_low_count", 32'(digit_count), 0);
      en = 1'b1;
      press(4'd12, 10, 4);
      check("bad_code_count", 32'(digit_count), 0);
      press(4'd8, 10, 4);
      check("after_bad_digit", 32'(sec_ones), 8);

      // reset mid-debounce with key held through release
      D = 4'd6; number = 1'b0;
      repeat (2) step();
      rst_n = 1'b0;
      #1;
      check("midrst_count", 32'(digit_count), 0);
      check("midrst_sec_ones", 32'(sec_ones), 0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (DC) step();
      check("postrst_early", 32'(digit_count), 0);
      step();
      check("postrst_count", 32'(digit_count), 1);
      check("postrst_digit", 32'(sec_ones), 6);
      number = 1'b1;
      repeat (3) step();

      // randomized traffic, checked every cycle by the model
      repeat (150) begin
         en = ($urandom % 8) != 0;
         if ($urandom % 6 == 0) begin
            clear = 1'b1; step(); clear = 1'b0;
         end
         rd = ($urandom % 5 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         press(rd, $urandom_range(1, DC + 4), $urandom_range(1, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
